// File: rtl/srio_type9_pack_logic.sv
// SRIO Ftype 9 packer: buffers one AXIS payload packet, then emits a
// HELLO header beat followed by the payload, splitting at MAX_BEATS.
module srio_type9_pack_logic #(
  parameter int         MAX_BEATS = 32,
  parameter logic [1:0] PRIO      = 2'b01
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic [63:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic        S_AXIS_TLAST,
  input  logic [3:0]  S_AXIS_TDEST,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TLAST,
  input  logic [31:0] cmd,
  input  logic [31:0] srio_streamID_if
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HDR,
    DRAIN
  } state_t;

  state_t      st, st_nx;
  logic [63:0] mem [MAX_BEATS];
  logic [5:0]  wr_cnt, rd_cnt, beats, beats_m1;
  logic [7:0]  tid_cnt;
  logic        sel, sel_now;
  logic [15:0] sid;
  logic        s_xfr, m_xfr, fill_end, rd_last, srst;
  logic [63:0] hdr;
  logic        unused;

  assign unused   = ^{cmd[31:2], S_AXIS_TDEST[3:1]};
  assign srst     = cmd[1];
  assign s_xfr    = S_AXIS_TVALID & S_AXIS_TREADY;
  assign m_xfr    = M_AXIS_TVALID & M_AXIS_TREADY;
  assign fill_end = s_xfr &
                    (S_AXIS_TLAST |
                     (wr_cnt == 6'(MAX_BEATS - 1)));
  assign beats_m1 = beats - 6'd1;
  assign rd_last  = (rd_cnt == beats_m1);
  // a 1-beat packet must use the TDEST captured in the same cycle
  assign sel_now  = (wr_cnt == 6'd0) ? S_AXIS_TDEST[0] : sel;
  // SIZE = beats*8-1, i.e. (beats-1) with the low byte-lane bits set
  assign hdr = {tid_cnt, 4'h9, 5'd0, PRIO, 1'b0,
                beats_m1[4:0], 3'b111, 4'd0, sid, 16'd0};

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) st <= IDLE;
    else             st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (srst) begin
      st_nx = IDLE;
    end else begin
      unique case (st)
        IDLE:    if (cmd[0]) st_nx = FILL;
        FILL:    if (fill_end) st_nx = HDR;
        HDR:     if (m_xfr) st_nx = DRAIN;
        DRAIN:   if (m_xfr && rd_last)
                   st_nx = cmd[0] ? FILL : IDLE;
        default: st_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TDATA  = '0;
    unique case (st)
      FILL: S_AXIS_TREADY = 1'b1;
      HDR: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = hdr;
      end
      DRAIN: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = mem[rd_cnt[4:0]];
        M_AXIS_TLAST  = rd_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (s_xfr) mem[wr_cnt[4:0]] <= S_AXIS_TDATA;
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      beats   <= '0;
      tid_cnt <= '0;
      sel     <= 1'b0;
      sid     <= '0;
    end else if (srst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      beats   <= '0;
      tid_cnt <= '0;
    end else begin
      unique case (st)
        FILL: if (s_xfr) begin
          if (wr_cnt == 6'd0) sel <= S_AXIS_TDEST[0];
          if (fill_end) begin
            beats  <= wr_cnt + 6'd1;
            wr_cnt <= '0;
            sid    <= sel_now ? srio_streamID_if[31:16]
                              : srio_streamID_if[15:0];
          end else begin
            wr_cnt <= wr_cnt + 6'd1;
          end
        end
        HDR: if (m_xfr) rd_cnt <= '0;
        DRAIN: if (m_xfr) begin
          rd_cnt <= rd_cnt + 6'd1;
          if (rd_last) tid_cnt <= tid_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srio_type9_pack_logic.sv
// Bench for srio_type9_pack_logic: packet-level model plus
// literal header/data checks.
module tb_srio_type9_pack_logic;

  localparam int MAXB = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic        s_valid, s_ready, s_last;
  logic [3:0]  s_dest;
  logic [63:0] m_data;
  logic        m_valid, m_ready, m_last;
  logic [31:0] cmd;
  logic [31:0] sids;

  logic rnd_mode = 1'b0;
  logic rnd_bit  = 1'b0;
  logic ready_set = 1'b1;
  assign m_ready = rnd_mode ? rnd_bit : ready_set;

  srio_type9_pack_logic dut (
    .AXIS_ACLK(clk),
    .AXIS_ARESET(rst),
    .S_AXIS_TDATA(s_data),
    .S_AXIS_TVALID(s_valid),
    .S_AXIS_TREADY(s_ready),
    .S_AXIS_TLAST(s_last),
    .S_AXIS_TDEST(s_dest),
    .M_AXIS_TDATA(m_data),
    .M_AXIS_TVALID(m_valid),
    .M_AXIS_TREADY(m_ready),
    .M_AXIS_TLAST(m_last),
    .cmd(cmd),
    .srio_streamID_if(sids)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int n_cmp = 0;
  int n_bad = 0;
  int tid_m = 0;
  logic [63:0] qd[$];
  logic        ql[$];
  logic [63:0] obs[$];
  logic        obs_l[$];

  function automatic logic [63:0] mk_hdr(
    input int tid, input int n, input logic [15:0] sid);
    logic [7:0] sz;
    sz = 8'(n * 8 - 1);
    return {8'(tid), 4'h9, 5'd0, 2'b01, 1'b0,
            sz, 4'd0, sid, 16'd0};
  endfunction

  // expected SRIO stream for one source packet
  function automatic void model_pkt(
    input int n, input bit dest, input logic [63:0] base);
    logic [15:0] sid;
    int m;
    sid = dest ? sids[31:16] : sids[15:0];
    for (int off = 0; off < n; off += MAXB) begin
      m = (n - off < MAXB) ? n - off : MAXB;
      qd.push_back(mk_hdr(tid_m, m, sid));
      ql.push_back(1'b0);
      for (int i = 0; i < m; i++) begin
        qd.push_back(base + 64'(off + i));
        ql.push_back(i == m - 1);
      end
      tid_m = (tid_m + 1) % 256;
    end
  endfunction

  task automatic chk64(input string nm,
    input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic        prev_stall = 1'b0;
  logic [63:0] pd;
  logic        pl;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (m_valid) begin
        n_cmp++;
        if (s_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL s_ready_busy: got %b want 0", s_ready);
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
          n_bad++;
          $display("FAIL stall_hold: got v%b %h l%b want v1 %h l%b",
                   m_valid, m_data, m_last, pd, pl);
        end
      end
      if (m_valid && m_ready) begin
        obs.push_back(m_data);
        obs_l.push_back(m_last);
        n_cmp++;
        if (qd.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got %h want none", m_data);
        end else begin
          if (m_data !== qd[0] || m_last !== ql[0]) begin
            n_bad++;
            $display("FAIL out_beat: got %h l%b want %h l%b",
                     m_data, m_last, qd[0], ql[0]);
          end
          void'(qd.pop_front());
          void'(ql.pop_front());
        end
      end
      prev_stall = m_valid & ~m_ready & ~cmd[1];
      pd = m_data;
      pl = m_last;
    end
  end

  task automatic put_beat(input logic [63:0] d,
    input bit l, input bit dest);
    int t;
    bit ok;
    t = 0;
    s_data = d;
    s_last = l;
    s_dest = {3'b0, dest};
    s_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 2000);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL s_handshake: got timeout want accept");
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit dest,
    input logic [63:0] base);
    model_pkt(n, dest, base);
    for (int i = 0; i < n; i++)
      put_beat(base + 64'(i), i == n - 1, dest);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (qd.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (qd.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d left want 0", qd.size());
      qd.delete();
      ql.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end

  int b;

  initial begin
    rst = 1'b1;
    s_data = '0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_dest = '0;
    cmd = '0;
    sids = 32'h0002_0001;
    @(negedge clk);
    chk64("rst_s_ready", 64'(s_ready), 64'd0);
    chk64("rst_m_valid", 64'(m_valid), 64'd0);
    chk64("rst_m_data", m_data, 64'd0);
    chk64("rst_m_last", 64'(m_last), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd = 32'h1;

    // 1: 4-beat packet on stream 0
    b = obs.size();
    send_pkt(4, 1'b0, 64'hD000_0000_0000_0000);
    wait_drain();
    chk64("t1_hdr", obs[b], 64'h009021F0_00010000);
    chk64("t1_d3", obs[b+4], 64'hD000_0000_0000_0003);
    chk64("t1_last", 64'({obs_l[b+3], obs_l[b+4]}), 64'b01);

    // 2: 2-beat on stream 1, then 1-beat packet
    b = obs.size();
    send_pkt(2, 1'b1, 64'hE000_0000_0000_0000);
    wait_drain();
    send_pkt(1, 1'b0, 64'hF000_0000_0000_0000);
    wait_drain();
    chk64("t2_hdr_a", obs[b], 64'h019020F0_00020000);
    chk64("t2_hdr_b", obs[b+3], 64'h02902070_00010000);
    chk64("t2_single", obs[b+4], 64'hF000_0000_0000_0000);
    chk64("t2_single_last", 64'(obs_l[b+4]), 64'd1);

    // 3: 40-beat source packet splits 32 + 8
    b = obs.size();
    send_pkt(40, 1'b0, 64'h1000_0000_0000_0000);
    wait_drain();
    chk64("t3_hdr_a", obs[b], 64'h03902FF0_00010000);
    chk64("t3_last_a", 64'({obs_l[b+31], obs_l[b+32]}), 64'b01);
    chk64("t3_hdr_b", obs[b+33], 64'h049023F0_00010000);
    chk64("t3_tail", obs[b+41], 64'h1000_0000_0000_0027);

    // 4: random downstream backpressure
    rnd_mode = 1'b1;
    send_pkt(5, 1'b1, 64'h2000_0000_0000_0000);
    wait_drain();
    send_pkt(33, 1'b0, 64'h3000_0000_0000_0000);
    wait_drain();
    send_pkt(1, 1'b1, 64'h4000_0000_0000_0000);
    wait_drain();
    rnd_mode = 1'b0;

    // 5: soft reset after header + 2 payload beats
    ready_set = 1'b0;
    b = obs.size();
    send_pkt(4, 1'b0, 64'h5000_0000_0000_0000);
    ready_set = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      if (obs.size() >= b + 3) break;
    end
    #1;
    ready_set = 1'b0;
    cmd = 32'h2;
    @(posedge clk);
    #1;
    cmd = 32'h0;
    qd.delete();
    ql.delete();
    tid_m = 0;
    ready_set = 1'b1;
    @(negedge clk);
    chk64("t5_valid_off", 64'(m_valid), 64'd0);
    chk64("t5_idle_ready", 64'(s_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk64("t5_still_idle", 64'(s_ready), 64'd0);
    cmd = 32'h1;
    b = obs.size();
    send_pkt(2, 1'b0, 64'h6000_0000_0000_0000);
    wait_drain();
    chk64("t5_hdr", obs[b], 64'h009020F0_00010000);

    // 6: async reset mid-fill
    put_beat(64'h7000_0000_0000_0000, 1'b0, 1'b0);
    put_beat(64'h7000_0000_0000_0001, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk64("t6_s_ready", 64'(s_ready), 64'd0);
    chk64("t6_m_valid", 64'(m_valid), 64'd0);
    cmd = 32'h0;
    tid_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd = 32'h1;
    b = obs.size();
    send_pkt(3, 1'b1, 64'h8000_0000_0000_0000);
    wait_drain();
    chk64("t6_hdr", obs[b], 64'h00902170_00020000);
    chk64("t6_d0", obs[b+1], 64'h8000_0000_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/srio_type9_pack_logic.md
Name: srio_type9_pack_logic

Overview:
Upstream counterpart of the SRIO Ftype 9 unpacker. Accepts 64-bit AXI-Stream payload packets tagged by TDEST, buffers one packet and emits an SRIO Ftype 9 (streaming) packet in HELLO format: one header beat followed by the payload beats. TDEST[0] selects one of two 16-bit SRIO streamIDs, each mapped to an ad9361 branch on the TD-SRD board. Packets longer than the SRIO 256-byte payload limit are split into several SRIO packets.

Parameters:
MAX_BEATS, 32, maximum payload beats per SRIO packet; legal range 1..32 (32 beats = 256 bytes).
PRIO, 2'b01, value placed in the header PRIO field.

Ports:
AXIS_ACLK  in  1  clock
AXIS_ARESET  in  1  asynchronous, active-high reset
S_AXIS_TDATA  in  64  payload beat
S_AXIS_TVALID  in  1  payload valid
S_AXIS_TREADY  out  1  payload ready
S_AXIS_TLAST  in  1  last payload beat of the source packet
S_AXIS_TDEST  in  4  stream select; only bit 0 is used
M_AXIS_TDATA  out  64  header or payload beat to SRIO
M_AXIS_TVALID  out  1  output valid
M_AXIS_TREADY  in  1  output ready
M_AXIS_TLAST  out  1  last beat of the SRIO packet
cmd  in  32  bit 0 = start/enable; bit 1 = soft reset
srio_streamID_if  in  32  [15:0] = streamID_0, [31:16] = streamID_1

Behaviour:
- Transfer definitions: s_xfr = S_AXIS_TVALID & S_AXIS_TREADY; m_xfr = M_AXIS_TVALID & M_AXIS_TREADY.
- Storage: buffer of MAX_BEATS x 64 bits with combinational read. Counters: wr_cnt, rd_cnt, beats (6 bits each), tid_cnt (8 bits). Registers: sel (1 bit), sid (16 bits).
- AXIS_ARESET asserted: immediately, with no clock edge, go to IDLE; all counters and sel/sid = 0; M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, M_AXIS_TDATA = 0, S_AXIS_TREADY = 0.
- cmd[1]: synchronous soft reset with the highest priority. Next state is IDLE, all counters clear, and tid_cnt = 0. An output packet in progress is truncated without TLAST; the downstream block must also be reset.
- IDLE: S_AXIS_TREADY = 0 and M_AXIS_TVALID = 0. If cmd[0] = 1, go to FILL.
- FILL:
  - S_AXIS_TREADY = 1 and M_AXIS_TVALID = 0.
  - Each s_xfr writes buf[wr_cnt] and increments wr_cnt.
  - On an s_xfr with wr_cnt = 0, capture sel = S_AXIS_TDEST[0].
  - An s_xfr with S_AXIS_TLAST = 1, or with wr_cnt = MAX_BEATS-1, ends the fill:
    - beats = wr_cnt + 1; wr_cnt = 0;
    - sid = sel ? srio_streamID_if[31:16] : srio_streamID_if[15:0], using the sel value that applies to this packet, including the same-cycle capture for a 1-beat packet;
    - go to HDR.
  - Forced split: remaining source beats start a new SRIO packet. TDEST is re-sampled on its first beat.
- HDR:
  - S_AXIS_TREADY = 0, M_AXIS_TVALID = 1, M_AXIS_TLAST = 0.
  - M_AXIS_TDATA header layout:
    - [63:56] tid_cnt
    - [55:52] 4'h9 (FTYPE)
    - [51:47] 0
    - [46:45] PRIO
    - [44] 0 (CRF)
    - [43:36] beats*8-1 (SIZE, payload bytes minus 1)
    - [35:32] 0
    - [31:16] sid
    - [15:0] 0
  - On m_xfr: rd_cnt = 0, go to DRAIN.
- DRAIN:
  - S_AXIS_TREADY = 0, M_AXIS_TVALID = 1, M_AXIS_TDATA = buf[rd_cnt], M_AXIS_TLAST = (rd_cnt == beats-1).
  - Each m_xfr increments rd_cnt.
  - On the m_xfr with TLAST: tid_cnt increments (wraps 255 to 0); go to FILL if cmd[0] = 1, else IDLE.
- cmd[0] deasserted in FILL or HDR has no effect until the current packet finishes.
- While M_AXIS_TREADY = 0, M_AXIS_TDATA and M_AXIS_TLAST hold stable.
- Latency: the header is valid in the cycle after the last payload beat is accepted.
- Throughput: an N-beat packet takes N input cycles plus N+1 output cycles; fill and drain do not overlap.
- No TKEEP support: all beats are full 8-byte beats.

Test Plan:
1. Assert AXIS_ARESET, release, set cmd = 1 and srio_streamID_if = 32'h0002_0001. Send 4 beats D0..D3 with TDEST = 0, TLAST on D3, M_AXIS_TREADY = 1. Expected: header with [63:56] = 0, [55:52] = 9, [43:36] = 8'h1F, [31:16] = 16'h0001; then D0..D3 with TLAST only on D3.
2. Send 2 beats with TDEST = 1. Expected: header streamID 16'h0002, TID 1, SIZE 8'h0F. Then send a 1-beat packet. Expected: SIZE 8'h07, TID 2, TLAST on its single payload beat.
3. Send a 40-beat source packet. Expected: two SRIO packets. First has SIZE 8'hFF, 32 payload beats, TLAST on beat 32. Second has SIZE 8'h3F, 8 payload beats, TID incremented. Data order is preserved.
4. Toggle M_AXIS_TREADY randomly at 50%. Expected: TDATA/TLAST stable while stalled; S_AXIS_TREADY = 0 throughout HDR and DRAIN; no beats lost or duplicated.
5. Pulse cmd[1] after 2 payload beats of the drain. Expected: next cycle M_AXIS_TVALID = 0 and state IDLE. After cmd[0] is set again, the next header carries TID 0.
6. Assert AXIS_ARESET mid-FILL between clock edges. Expected: S_AXIS_TREADY and M_AXIS_TVALID = 0 immediately. After release and start, a fresh packet carries TID 0 and starts writing at buffer index 0.
